// File: rtl/updown_counter_param.sv
// updown_counter_param
// General-purpose timing/event counter: width-parameterised up/down count with a
// programmable terminal value, parallel load, wrap or saturate at the bounds, an
// enable prescaler, a one-cycle terminal-count pulse and a sticky overflow flag.
// Everything updates on the rising edge of clk; reset is synchronous and active-low.
//
// Priority on each edge: reset > load > step > hold.
//  - The upper bound is 'limit'. The lower bound is zero.
//  - A "bound event" is a step that hits a bound:
//      up:   count >= limit
//      down: count == 0
//  - On a bound event, count wraps to the other bound.
//    With SATURATE=1 it holds at the bound it reached instead.
//  - A down step taken while count is above limit (because limit was lowered)
//    snaps count to limit rather than decrementing.

module updown_counter_param #(
  parameter int WIDTH    = 20,
  parameter int PRE_W    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] div,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             tc,
  output logic             ovf
);

  logic [PRE_W-1:0] pre_cnt;
  logic             step;
  logic             bound;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;

  // The prescaler phase is compared with equality only.
  // If div is lowered below the current phase, the phase runs up,
  // wraps modulo 2^PRE_W, and fires when it passes through div again.
  assign step = en && (pre_cnt == div);

  assign at_max = (count == limit);
  assign at_min = (count == '0);

  // Loaded values above the terminal value are clamped to it.
  always_comb begin
    load_clamped = load_val;
    if (load_val > limit) begin
      load_clamped = limit;
    end
  end

  // Value one step would produce in the sampled direction, and whether that step is a bound event.
  always_comb begin
    bound    = 1'b0;
    step_val = count;
    if (up_dn) begin
      if (count >= limit) begin
        bound    = 1'b1;
        step_val = SATURATE ? limit : '0;
      end else begin
        step_val = count + 1'b1;
      end
    end else begin
      if (count == '0) begin
        bound    = 1'b1;
        step_val = SATURATE ? '0 : limit;
      end else if (count > limit) begin
        step_val = limit;
      end else begin
        step_val = count - 1'b1;
      end
    end
  end

  // Prescaler phase: restarted by reset/load, advances only while enabled, restarts on a step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (load) begin
      pre_cnt <= '0;
    end else if (en) begin
      if (step) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  // Counter value, terminal-count pulse and sticky overflow.
  // A new bound event takes precedence over clr_ovf.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      tc    <= 1'b0;
      if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end else begin
      tc <= step && bound;
      if (step) begin
        count <= step_val;
      end
      if (step && bound) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
